// File: rtl/decoder_4x16_if.sv
// Bundle for the 4-to-16 decoder: select/enable inputs and registered one-hot result.
interface decoder_4x16_if;
    logic        en;
    logic [3:0]  in;
    logic [15:0] out;
    logic        hit;

    modport master (
        output en,
        output in,
        input  out,
        input  hit
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output hit
    );
endinterface

// File: rtl/decoder_4x16.sv
// Registered 4-to-16 one-hot decoder with enable, one cycle of latency.
// Define DEC_4X16_ASSERT_EN to compile in simulation-only consistency checks.
module decoder_4x16 (
    input  logic           clk,
    input  logic           rst,
    decoder_4x16_if.slave  bus
);

    logic [15:0] out_reg;
    logic [15:0] out_next;
    logic        hit_reg;
    logic        hit_next;

    // Each line compares the code against its own index; gating with en first
    // keeps an unknown code from leaking through while the block is disabled.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_dec
            assign out_next[gi] = bus.en && (bus.in == 4'(gi));
        end
    endgenerate

    assign hit_next = bus.en;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= 16'h0000;
            hit_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            hit_reg <= hit_next;
        end
    end

    assign bus.out = out_reg;
    assign bus.hit = hit_reg;

`ifdef DEC_4X16_ASSERT_EN
    logic [31:0] cycle_reg;
    logic        en_d_reg;
    logic [3:0]  in_d_reg;
    logic        rst_d_reg;

    // Values read here are pre-edge, so out reflects the inputs captured one
    // edge earlier, which is exactly what en_d_reg/in_d_reg hold.
    always_ff @(posedge clk) begin
        cycle_reg <= rst ? 32'd0 : cycle_reg + 32'd1;
        en_d_reg  <= bus.en;
        in_d_reg  <= bus.in;
        rst_d_reg <= rst;
        if (!rst && !rst_d_reg) begin
            if (!$onehot0(bus.out))
                $error("decoder_4x16: cycle %0d out=%h is not zero/one-hot", cycle_reg, bus.out);
            if (bus.hit != (|bus.out))
                $error("decoder_4x16: cycle %0d hit=%b disagrees with out=%h", cycle_reg, bus.hit, bus.out);
            if (bus.out != (en_d_reg ? (16'h0001 << in_d_reg) : 16'h0000))
                $error("decoder_4x16: cycle %0d out=%h wrong for en=%b in=%0d",
                       cycle_reg, bus.out, en_d_reg, in_d_reg);
        end
    end
`endif

endmodule

// File: tb/tb_decoder_4x16.sv
// Scoreboard bench for decoder_4x16: directed steps push expectations, a negedge monitor checks them.
module tb_decoder_4x16;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    decoder_4x16_if bus ();

    decoder_4x16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] out;
        logic        hit;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    logic [15:0] walk [16] = '{
        16'h0001, 16'h0002, 16'h0004, 16'h0008,
        16'h0010, 16'h0020, 16'h0040, 16'h0080,
        16'h0100, 16'h0200, 16'h0400, 16'h0800,
        16'h1000, 16'h2000, 16'h4000, 16'h8000
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every entry is due at the negedge following its target edge.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            checks++;
            if (bus.out !== mon_e.out || bus.hit !== mon_e.hit) begin
                errors++;
                $display("FAIL %s: got out=%h hit=%b, expected out=%h hit=%b",
                         mon_e.name, bus.out, bus.hit, mon_e.out, mon_e.hit);
            end else begin
                $display("ok   %s: out=%h hit=%b", mon_e.name, bus.out, bus.hit);
            end
        end
    end

    // Apply inputs just after an edge; the result is due after the following edge.
    task automatic step(input logic r, input logic e, input logic [3:0] i,
                        input logic [15:0] exp_out, input logic exp_hit, input string name);
        exp_t x;
        @(posedge clk);
        #1;
        rst    = r;
        bus.en = e;
        bus.in = i;
        x.cyc  = cyc + 1;
        x.out  = exp_out;
        x.hit  = exp_hit;
        x.name = name;
        sbq.push_back(x);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.en = 1'b1;
        bus.in = 4'd7;

        step(1'b1, 1'b1, 4'd7, 16'h0000, 1'b0, "reset0");
        step(1'b1, 1'b1, 4'd7, 16'h0000, 1'b0, "reset1");
        step(1'b0, 1'b1, 4'd7, 16'h0080, 1'b1, "release_in7");

        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 4'(i), 16'h0000, 1'b0, $sformatf("dis_in%0d", i));

        for (int i = 0; i < 16; i++) begin
            if (i == 9) begin
                step(1'b1, 1'b1, 4'd9, 16'h0000, 1'b0, "midreset_in9");
                step(1'b0, 1'b1, 4'd9, 16'h0200, 1'b1, "resume_in9");
            end else begin
                step(1'b0, 1'b1, 4'(i), walk[i], 1'b1, $sformatf("en_in%0d", i));
            end
        end

        step(1'b0, 1'b1, 4'b1010, 16'h0400, 1'b1, "spot_1010");
        step(1'b0, 1'b1, 4'b1111, 16'h8000, 1'b1, "spot_1111");
        step(1'b0, 1'b1, 4'b0000, 16'h0001, 1'b1, "spot_0000");

        step(1'b0, 1'b1, 4'd3, 16'h0008, 1'b1, "tog_en1");
        step(1'b0, 1'b0, 4'd3, 16'h0000, 1'b0, "tog_en0");
        step(1'b0, 1'b1, 4'd3, 16'h0008, 1'b1, "tog_en1b");

        step(1'b0, 1'b0, 4'bxxxx, 16'h0000, 1'b0, "dis_in_x");
        step(1'b0, 1'b1, 4'd12, 16'h1000, 1'b1, "after_x_in12");

        for (int w = 0; w < 20 && sbq.size() > 0; w++)
            @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
